// File: rtl/rv32i_fetch_pkg.sv
// Shared state encoding and constants for the rv32i instruction-fetch controller
// and its redirect arbiter.
package rv32i_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic word_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/rv32i_redirect_arb.sv
// Combinational redirect arbiter: branch > JAL > JALR priority, JALR bit-0 clear,
// and word-alignment check of the selected target.
module rv32i_redirect_arb
  import rv32i_fetch_pkg::*;
(
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  input  logic        i_jal,
  input  logic [31:0] i_jal_target,
  input  logic        i_jalr,
  input  logic [31:0] i_jalr_target,
  output logic        o_redirect,
  output logic [31:0] o_target,
  output logic        o_misaligned
);

  // Target selection by fixed priority
  always_comb begin
    o_target = 32'h0000_0000;
    if (i_br_taken) begin
      o_target = i_br_target;
    end else if (i_jal) begin
      o_target = i_jal_target;
    end else if (i_jalr) begin
      o_target = {i_jalr_target[31:1], 1'b0};
    end else begin
      o_target = 32'h0000_0000;
    end
  end

  assign o_redirect   = i_br_taken | i_jal | i_jalr;
  assign o_misaligned = o_redirect & word_misaligned(o_target);

endmodule

// File: rtl/rv32i_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues single outstanding imem requests,
// hands instructions to decode and applies execute-stage redirects with stale-response drop.
module rv32i_fetch_ctrl
  import rv32i_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jal,
  input  logic [31:0] jal_target,
  input  logic        jalr,
  input  logic [31:0] jalr_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        misalign_err
);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic         r_drop, w_drop_nxt;
  logic         w_capture;
  logic [31:0]  r_if_pc, r_if_instr;
  logic         r_misalign;
  logic         w_redirect, w_misaligned, w_redir_ok;
  logic [31:0]  w_target;

  rv32i_redirect_arb u_arb (
    .i_br_taken    (br_taken),
    .i_br_target   (br_target),
    .i_jal         (jal),
    .i_jal_target  (jal_target),
    .i_jalr        (jalr),
    .i_jalr_target (jalr_target),
    .o_redirect    (w_redirect),
    .o_target      (w_target),
    .o_misaligned  (w_misaligned)
  );

  assign w_redir_ok = w_redirect & ~w_misaligned;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, next pc and drop flag; drop marks the single in-flight response as wrong-path
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_drop_nxt  = r_drop;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = REQ;
        if (w_redir_ok) w_pc_nxt = w_target;
        else            w_pc_nxt = r_pc;
      end
      REQ: begin
        if (w_redir_ok) w_pc_nxt = w_target;
        else            w_pc_nxt = r_pc;
        if (imem_req_ready) begin
          w_state_nxt = WAIT;
          w_drop_nxt  = w_redir_ok;
        end else begin
          w_state_nxt = REQ;
        end
      end
      WAIT: begin
        if (w_redir_ok) begin
          w_pc_nxt = w_target;
          if (imem_rsp_valid) begin
            w_state_nxt = REQ;
            w_drop_nxt  = 1'b0;
          end else begin
            w_drop_nxt  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (r_drop) begin
            w_state_nxt = REQ;
            w_drop_nxt  = 1'b0;
          end else begin
            w_state_nxt = HOLD;
            w_capture   = 1'b1;
          end
        end else begin
          w_state_nxt = WAIT;
        end
      end
      HOLD: begin
        if (w_redir_ok) begin
          w_pc_nxt    = w_target;
          w_state_nxt = REQ;
        end else if (if_ready) begin
          w_pc_nxt    = r_pc + INSTR_BYTES;
          w_state_nxt = REQ;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // PC, drop flag, delivered instruction and misalignment pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc       <= RESET_PC;
      r_drop     <= 1'b0;
      r_if_pc    <= 32'h0000_0000;
      r_if_instr <= 32'h0000_0000;
      r_misalign <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_drop     <= w_drop_nxt;
      r_misalign <= w_misaligned;
      if (w_capture) begin
        r_if_pc    <= r_pc;
        r_if_instr <= imem_rsp_data;
      end
    end
  end

  // Handshake outputs; if_valid is masked in a redirect cycle so a wrong-path word never leaves
  always_comb begin
    imem_req_valid = (r_state == REQ);
    if_valid       = (r_state == HOLD) & ~w_redir_ok;
  end

  assign imem_req_addr = r_pc;
  assign if_pc         = r_if_pc;
  assign if_instr      = r_if_instr;
  assign misalign_err  = r_misalign;

endmodule

// File: doc/rv32i_fetch_ctrl.md
# rv32i_fetch_ctrl

Instruction-fetch controller for the rv32i core. It owns the program counter and issues one-at-a-time requests to instruction memory. It presents fetched instructions to decode over a valid/ready handshake. It is the producer side of PC redirection: it consumes branch/JAL/JALR redirect requests from execute, resolves their priority, and squashes wrong-path fetches.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- br_taken  in  1  branch taken this cycle
- br_target  in  32  branch target
- jal  in  1  JAL this cycle
- jal_target  in  32  JAL target
- jalr  in  1  JALR this cycle
- jalr_target  in  32  JALR target (bit 0 cleared internally)
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address
- imem_rsp_valid  in  1  response data valid (one pulse per accepted request)
- imem_rsp_data  in  32  instruction word
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts instruction
- if_pc  out  32  PC of presented instruction
- if_instr  out  32  presented instruction
- misalign_err  out  1  one-cycle pulse: selected redirect target not word-aligned

## Operation
- States: IDLE, REQ, WAIT, HOLD. Reset state is IDLE, with pc = RESET_PC.
- IDLE -> REQ unconditionally.
- REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready, go to WAIT.
- WAIT: on imem_rsp_valid, capture data into if_instr and pc into if_pc, then go to HOLD. If the drop flag is set, discard the data, clear the flag, and go to REQ.
- HOLD: if_valid=1. On if_ready, set pc = pc+4 (mod 2^32) and go to REQ.
- Redirect resolution:
  - redirect = br_taken | jal | jalr.
  - Priority is branch > JAL > JALR; the selected target is t.
  - JALR target has bit 0 forced to 0 before the check.
  - If t[1:0] != 0: pulse misalign_err, ignore the redirect, and leave state unchanged.
- Valid redirect, by state:
  - IDLE or REQ: pc = t. If a REQ handshake completes in the same cycle, set the drop flag and go to WAIT. The address may change while valid is high and ready is low; imem has no address-stability rule.
  - WAIT: pc = t and set the drop flag. If imem_rsp_valid arrives in the same cycle, discard it and go to REQ instead.
  - HOLD: pc = t, discard the held instruction, and go to REQ.
- if_valid = (state==HOLD) & ~valid_redirect. This is combinational, so a wrong-path instruction is never handed over in the redirect cycle.
- At most one request is outstanding. The drop flag counts at most one stale response.

## Timing
- Reset values (all outputs): imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0, misalign_err=0. pc=RESET_PC and the drop flag is 0.
- Reset assertion mid-transaction aborts immediately. Any later imem response is not counted, because the drop flag is clear and the state is IDLE/REQ, not WAIT.
- First request: imem_req_valid rises in the 2nd cycle after reset_n deasserts (IDLE for 1 cycle).
- Minimum latency is 3 cycles per instruction with zero-wait memory (REQ, WAIT, HOLD).
- Redirect to new-address request: REQ is entered the next cycle, or immediately if the redirect occurs while already in REQ.
- misalign_err is registered and pulses the cycle after the offending redirect.

## Structure
- Package rv32i_fetch_pkg holds:
  - fetch_state_t enum (IDLE, REQ, WAIT, HOLD)
  - INSTR_BYTES=4
  - default RESET_PC constant
- Sub-module rv32i_redirect_arb is combinational. It takes the three request/target pairs and produces redirect, t, and misaligned (priority plus alignment check). The FSM, pc, and drop flag live in the top module.

## Test plan
- Reset: hold reset_n=0 for 3 cycles, then release. All outputs stay at their reset values. Cycle 2 after release shows imem_req_valid=1 with addr=0.
- Sequential fetch, zero-wait memory, if_ready=1: words at 0x0, 0x4, 0x8 appear on if_instr/if_pc every 3 cycles. Then pc wraps from 0xFFFF_FFFC to 0x0.
- Priority: br_taken, jal, and jalr all asserted together with targets 0x100, 0x200, 0x301. The next request address is 0x100. Next, jalr alone with target 0x301 fetches 0x300.
- Stale drop: redirect to 0x400 during WAIT, with the response arriving 2 cycles later. That response never raises if_valid, and the next request address is 0x400.
- Misaligned redirect: jal with target 0x202 during HOLD. misalign_err pulses for 1 cycle, and the held instruction is still delivered.
- Backpressure: imem_req_ready=0 for 5 cycles, then if_ready=0 for 4 cycles. imem_req_addr and if_instr stay stable, with exactly one request and one delivery.
